posit_stream_packer_16_1: RTL and testbench
===========================================

POSIT_STREAM_PACKER_16_1 -- requirements
Module: posit_stream_packer_16_1

Interface
REQ-001 SHALL have parameter WIDTH, 64, AXI-stream data width; only 64 is supported.
REQ-002 SHALL have parameter DEPTH, 4, number of FIFO entries; a power of 2 and at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports rts_i input 1 (source has data) and rtr_o output 1 (block can accept data).
REQ-006 SHALL have ports sow_i input 1 (start of window) and eow_i input 1 (end of window).
REQ-007 SHALL have ports fraction_i input 26, scale_i input 7 (signed), NaR_i input 1, zero_i input 1, sign_i input 1: the decoded product from the multiplier.
REQ-008 SHALL have ports m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tdata output WIDTH, m_axis_tstrb output WIDTH/8, m_axis_tlast output 1.
REQ-009 SHALL have ports proto_err_o output 1 (sticky framing error) and word_cnt_o output 16 (beats sent in the current window).

Function
REQ-010 SHALL accept an input beat only on a rising edge where rts_i=1 and rtr_o=1.
REQ-011 SHALL drive rtr_o = 1 exactly when the FIFO occupancy is less than DEPTH; rtr_o SHALL come from registered occupancy only.
REQ-012 SHALL form the 36-bit payload of each accepted beat as follows: bits [25:0] fraction_i, [32:26] scale_i, [33] NaR_i, [34] zero_i, [35] sign_i.
REQ-013 SHALL store each payload with its eow_i flag in a first-word-fall-through FIFO; read and write pointers wrap modulo DEPTH.
REQ-014 SHALL drive m_axis_tvalid = 1 exactly when the FIFO is non-empty.
REQ-015 While m_axis_tvalid=1, SHALL drive m_axis_tdata = head payload zero-extended to WIDTH, m_axis_tlast = head eow flag, and m_axis_tstrb = 8'h1F.
REQ-016 While m_axis_tvalid=0, SHALL drive m_axis_tdata, m_axis_tlast and m_axis_tstrb to 0.
REQ-017 SHALL have a latency of one cycle: a beat accepted at edge N is presented on m_axis at edge N.
REQ-018 SHALL pop the head entry on an edge where m_axis_tvalid=1 and m_axis_tready=1, and SHALL hold tdata/tlast stable while tvalid=1 and tready=0.
REQ-019 When the FIFO is full, SHALL NOT accept a beat even if a pop occurs in the same cycle (no pass-through).
REQ-020 Push and pop in the same cycle with the FIFO neither full nor empty SHALL leave occupancy unchanged.
REQ-021 SHALL run a window state machine with states IDLE and IN_WIN; these transitions are evaluated on accepted beats only.
REQ-022 IDLE with sow=1, eow=0 SHALL go to IN_WIN.
REQ-023 IN_WIN with eow=1 SHALL go to IDLE.
REQ-024 IDLE with sow=1, eow=1 SHALL remain IDLE (single-beat window).
REQ-025 SHALL set proto_err_o to 1 and keep it set until reset when a beat is accepted in IDLE with sow=0, or in IN_WIN with sow=1; the beat SHALL still be stored and the state SHALL still update per REQ-022 to REQ-024.
REQ-026 SHALL increment word_cnt_o on each popped beat with tlast=0, saturating at 16'hFFFF.
REQ-027 SHALL clear word_cnt_o to 0 on a popped beat with tlast=1.

Reset
REQ-028 On rst_n=0, SHALL immediately empty the FIFO and set state=IDLE.
REQ-029 On rst_n=0, SHALL immediately drive rtr_o=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tlast=0, proto_err_o=0, word_cnt_o=0.
REQ-030 SHALL assert rtr_o on the first rising edge after rst_n deasserts.
REQ-031 Reset during operation SHALL discard all buffered beats without emitting any of them.

Structure
REQ-032 Package posit_stream_pkg SHALL hold the constants FRAC_W=26, SCALE_W=7 and PAYLOAD_W=36.
REQ-033 posit_stream_pkg SHALL hold the payload bit-position constants and the window-state enum {IDLE, IN_WIN}.
REQ-034 The FIFO SHALL be a sub-module named sync_fifo, parameterised by data width (PAYLOAD_W+1) and DEPTH; the window FSM, counters and AXI mapping SHALL live in the top module.

Verification
REQ-035 Single beat with sow=1, eow=1, fraction=26'h0000800, scale=7'h02, sign=1, tready=1 -> next cycle tvalid=1, tdata=64'h0000_0008_0800_0800 (sign in bit 35, scale 2 at bits [32:26], fraction 26'h0000800 at bits [25:0]), tlast=1, tstrb=8'h1F, proto_err_o=0, word_cnt_o=0.
REQ-036 Window of 6 beats with tready=0 -> rtr_o drops after the 4th accept; releasing tready drains the 6 beats in order, tlast only on beat 6, word_cnt_o reaches 5 then returns to 0.
REQ-037 Random tready (50%) with 1000 continuous beats -> output sequence equals input sequence and no beat is lost or duplicated.
REQ-038 Beat with sow=0 after reset -> proto_err_o=1 and stays 1; beat is still emitted.
REQ-039 Second sow inside a window -> proto_err_o=1.
REQ-040 rst_n pulsed with 3 beats buffered -> tvalid=0 immediately, no buffered beat emitted after reset, rtr_o=1 on the first edge after release.

Source files
------------

// File: rtl/posit_stream_pkg.sv
// Shared constants, payload layout and window-state type for the posit stream packer.
// The payload struct field order fixes the bit positions on the AXI-stream data bus.
package posit_stream_pkg;

    localparam int FRAC_W    = 26;
    localparam int SCALE_W   = 7;
    localparam int PAYLOAD_W = 36;

    localparam int FRAC_LSB  = 0;
    localparam int SCALE_LSB = FRAC_LSB + FRAC_W;
    localparam int NAR_BIT   = SCALE_LSB + SCALE_W;
    localparam int ZERO_BIT  = NAR_BIT + 1;
    localparam int SIGN_BIT  = ZERO_BIT + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_WIN = 1'b1
    } win_state_t;

    typedef struct packed {
        logic               sign;
        logic               zero;
        logic               nar;
        logic [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]  fraction;
    } payload_t;

    function automatic payload_t pack_payload(
        input logic               sign,
        input logic               zero,
        input logic               nar,
        input logic [SCALE_W-1:0] scale,
        input logic [FRAC_W-1:0]  fraction
    );
        payload_t p;
        p.sign     = sign;
        p.zero     = zero;
        p.nar      = nar;
        p.scale    = scale;
        p.fraction = fraction;
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO, DEPTH entries, pointers wrap modulo DEPTH.
// Latency: a write is visible on rd_dat right after its edge.
// Backpressure: wr_rdy drops when full; a write while full is ignored even if a read occurs.
module sync_fifo #(
    parameter int DATA_W = 37,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [DATA_W-1:0] wr_dat,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [DATA_W-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    // Flags come from the registered count only, so a pop never frees space for a same-cycle push.
    assign wr_rdy = (count < (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/posit_stream_packer_16_1.sv
// Packs decoded posit products into AXI-stream beats and checks sow/eow window framing.
// Latency: beat accepted at edge N is on m_axis right after edge N.
// Backpressure: rtr_o deasserts while the FIFO is full; m_axis holds its beat while tready=0.
module posit_stream_packer_16_1
    import posit_stream_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rts_i,
    output logic                    rtr_o,
    input  logic                    sow_i,
    input  logic                    eow_i,
    input  logic [FRAC_W-1:0]       fraction_i,
    input  logic [SCALE_W-1:0]      scale_i,
    input  logic                    NaR_i,
    input  logic                    zero_i,
    input  logic                    sign_i,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [WIDTH-1:0]        m_axis_tdata,
    output logic [WIDTH/8-1:0]      m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic                    proto_err_o,
    output logic [15:0]             word_cnt_o
);

    localparam logic [WIDTH/8-1:0] TSTRB_VLD = {{(WIDTH/8-5){1'b0}}, 5'h1F};

    logic                 rdy_en;
    logic                 fifo_wr_rdy;
    logic                 accept;
    logic                 pop;
    payload_t             in_pl;
    logic [PAYLOAD_W:0]   head_dat;
    logic                 head_vld;
    win_state_t           state;
    win_state_t           state_nxt;
    logic                 err_set;

    // Holds rtr_o low through reset and until the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign rtr_o  = rdy_en & fifo_wr_rdy;
    assign accept = rts_i & rtr_o;
    assign in_pl  = pack_payload(sign_i, zero_i, NaR_i, scale_i, fraction_i);

    sync_fifo #(
        .DATA_W (PAYLOAD_W + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (accept),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat ({eow_i, in_pl}),
        .rd_vld (head_vld),
        .rd_rdy (m_axis_tready),
        .rd_dat (head_dat)
    );

    assign pop           = head_vld & m_axis_tready;
    assign m_axis_tvalid = head_vld;
    assign m_axis_tdata  = head_vld ? {{(WIDTH-PAYLOAD_W){1'b0}}, head_dat[PAYLOAD_W-1:0]} : '0;
    assign m_axis_tlast  = head_vld & head_dat[PAYLOAD_W];
    assign m_axis_tstrb  = head_vld ? TSTRB_VLD : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Framing errors never block the beat; they only set the sticky flag.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!sow_i)          err_set   = 1'b1;
                    if (sow_i && !eow_i) state_nxt = IN_WIN;
                end
                IN_WIN: begin
                    if (sow_i) err_set   = 1'b1;
                    if (eow_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       proto_err_o <= 1'b0;
        else if (err_set) proto_err_o <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_o <= '0;
        end else if (pop) begin
            if (m_axis_tlast)                word_cnt_o <= '0;
            else if (word_cnt_o != 16'hFFFF) word_cnt_o <= word_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_posit_stream_packer_16_1.sv
// Scoreboard bench: driver pushes modelled beats, negedge monitor compares m_axis output.
module tb_posit_stream_packer_16_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rts_i = 1'b0;
    logic        rtr_o;
    logic        sow_i = 1'b0;
    logic        eow_i = 1'b0;
    logic [25:0] fraction_i = '0;
    logic [6:0]  scale_i = '0;
    logic        NaR_i = 1'b0;
    logic        zero_i = 1'b0;
    logic        sign_i = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tstrb;
    logic        m_axis_tlast;
    logic        proto_err_o;
    logic [15:0] word_cnt_o;

    logic        fixed_rdy = 1'b0;
    logic        rand_rdy  = 1'b0;
    logic        rnd_bit   = 1'b0;
    assign m_axis_tready = rand_rdy ? rnd_bit : fixed_rdy;

    posit_stream_packer_16_1 #(.WIDTH(64), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rts_i         (rts_i),
        .rtr_o         (rtr_o),
        .sow_i         (sow_i),
        .eow_i         (eow_i),
        .fraction_i    (fraction_i),
        .scale_i       (scale_i),
        .NaR_i         (NaR_i),
        .zero_i        (zero_i),
        .sign_i        (sign_i),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .proto_err_o   (proto_err_o),
        .word_cnt_o    (word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dat;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   exp_wcnt = 0;
    bit   m_in_win = 1'b0;
    bit   m_err    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference layout: sign at 2^35, zero at 2^34, NaR at 2^33, scale at 2^26, fraction at 2^0.
    function automatic logic [63:0] model_word(input bit s, input bit z, input bit n,
                                               input logic [6:0] sc, input logic [25:0] fr);
        return 64'(s) * (64'd1 << 35) + 64'(z) * (64'd1 << 34) + 64'(n) * (64'd1 << 33)
             + 64'(sc) * (64'd1 << 26) + 64'(fr);
    endfunction

    task automatic send(input bit sow, input bit eow, input bit s, input bit z, input bit n,
                        input logic [6:0] sc, input logic [25:0] fr);
        exp_t e;
        int   t = 0;
        rts_i = 1'b1; sow_i = sow; eow_i = eow;
        sign_i = s; zero_i = z; NaR_i = n; scale_i = sc; fraction_i = fr;
        @(negedge clk);
        while (!rtr_o && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!rtr_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: rtr_o stayed 0 for %0d cycles, expected 1", t);
            rts_i = 1'b0;
            return;
        end
        e.dat  = model_word(s, z, n, sc, fr);
        e.last = eow;
        exp_q.push_back(e);
        n_pushed++;
        m_err    = m_err | (m_in_win ? sow : !sow);
        m_in_win = eow ? 1'b0 : (m_in_win | sow);
        @(posedge clk);
        #1;
        rts_i = 1'b0;
        check("proto_err", 64'(proto_err_o), 64'(m_err));
    endtask

    task automatic send_rand(input bit sow, input bit eow);
        send(sow, eow, 1'($urandom), 1'($urandom), 1'($urandom),
             7'($urandom), 26'($urandom));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        m_in_win = 1'b0;
        m_err    = 1'b0;
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_rtr", 64'(rtr_o), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast_tstrb", {55'd0, m_axis_tlast, m_axis_tstrb}, 64'd0);
        check("rst_proto_err", 64'(proto_err_o), 64'd0);
        check("rst_word_cnt", 64'(word_cnt_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rtr_before_first_edge", 64'(rtr_o), 64'd0);
        @(posedge clk);
        #1;
        check("rtr_after_first_edge", 64'(rtr_o), 64'd1);
    endtask

    // Monitor: head must match the scoreboard every cycle, so stability under tready=0 is covered.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_wcnt = 0;
        end else if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", m_axis_tdata);
            end else begin
                check("tdata", m_axis_tdata, exp_q[0].dat);
                check("tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
                check("tstrb", 64'(m_axis_tstrb), 64'h1F);
                if (m_axis_tready) begin
                    check("word_cnt", 64'(word_cnt_o), 64'(exp_wcnt));
                    exp_wcnt = exp_q[0].last ? 0 : ((exp_wcnt == 65535) ? 65535 : exp_wcnt + 1);
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end else begin
            check("idle_tdata", m_axis_tdata, 64'd0);
            check("idle_tlast_tstrb", {55'd0, m_axis_tlast, m_axis_tstrb}, 64'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d beats still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int len;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #10;
        check("init_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("init_rtr", 64'(rtr_o), 64'd0);
        check("init_tdata", m_axis_tdata, 64'd0);
        check("init_tlast_tstrb", {55'd0, m_axis_tlast, m_axis_tstrb}, 64'd0);
        check("init_proto_err", 64'(proto_err_o), 64'd0);
        check("init_word_cnt", 64'(word_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_rtr_before_edge", 64'(rtr_o), 64'd0);
        @(posedge clk);
        #1;
        check("init_rtr_after_edge", 64'(rtr_o), 64'd1);

        // Single-beat window with known field values.
        fixed_rdy = 1'b1;
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'h02, 26'h0000800);
        check("single_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("single_tdata", m_axis_tdata, 64'h0000_0008_0800_0800);
        check("single_tlast", 64'(m_axis_tlast), 64'd1);
        check("single_tstrb", 64'(m_axis_tstrb), 64'h1F);
        check("single_word_cnt", 64'(word_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        check("single_word_cnt_after", 64'(word_cnt_o), 64'd0);
        check("single_drained", 64'(m_axis_tvalid), 64'd0);

        // Six-beat window against a stalled sink.
        fixed_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(i == 0, 1'b0);
        check("full_rtr", 64'(rtr_o), 64'd0);
        check("full_tvalid", 64'(m_axis_tvalid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("full_rtr_held", 64'(rtr_o), 64'd0);
        fixed_rdy = 1'b1;
        send_rand(1'b0, 1'b0);
        send_rand(1'b0, 1'b1);
        drain();
        check("win6_word_cnt", 64'(word_cnt_o), 64'd0);

        // Long random run with random sink readiness.
        rand_rdy = 1'b1;
        sent = 0;
        while (sent < 1000) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) send_rand(k == 0, k == len - 1);
            sent += len;
        end
        drain();
        rand_rdy = 1'b0;
        check("rand_count", 64'(n_popped), 64'(n_pushed));
        check("rand_proto_err", 64'(proto_err_o), 64'd0);

        // Beat without sow straight after reset.
        do_reset();
        fixed_rdy = 1'b1;
        send_rand(1'b0, 1'b0);
        send_rand(1'b0, 1'b1);
        send_rand(1'b1, 1'b1);
        drain();
        check("nosow_sticky", 64'(proto_err_o), 64'd1);

        // Second sow inside an open window.
        do_reset();
        send_rand(1'b1, 1'b0);
        send_rand(1'b1, 1'b0);
        send_rand(1'b0, 1'b1);
        drain();
        check("dblsow_err", 64'(proto_err_o), 64'd1);

        // Reset with three beats buffered: none may appear afterwards.
        fixed_rdy = 1'b0;
        send_rand(1'b1, 1'b0);
        send_rand(1'b0, 1'b0);
        send_rand(1'b0, 1'b1);
        check("buffered_tvalid", 64'(m_axis_tvalid), 64'd1);
        do_reset();
        fixed_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("post_reset_word_cnt", 64'(word_cnt_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
